// File: rtl/mac_pkg.sv
// Shared definitions for the MAC column: datapath widths, buffer depth and the
// feeder state encoding. The MAC PE imports this package as well.
package mac_pkg;

  localparam int W_BITWIDTH     = 8;
  localparam int IFMAP_BITWIDTH = 16;
  localparam int DEPTH          = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PREFETCH,
    ST_STREAM,
    ST_DONE
  } feeder_state_t;

  // A stream must carry at least one pair and must fit in the buffers.
  function automatic logic len_legal(input int unsigned len, input int unsigned depth);
    return (len >= 1) && (len <= depth);
  endfunction

endpackage

// File: rtl/feeder_buf.sv
// Small register file: one synchronous write port and one asynchronous read
// port. Used once for weights and once for ifmaps inside mac_feeder.
module feeder_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic signed [WIDTH-1:0] rdata
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset on purpose; every entry is written before the
  // feeder reads it, so clearing it would only cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mac_feeder.sv
// Loads a weight/ifmap stream of cfg_len pairs through two ready/valid ports,
// then replays it to a MAC column: one prefetch strobe, len enabled data beats, done.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int W_BITWIDTH     = mac_pkg::W_BITWIDTH,
  parameter int IFMAP_BITWIDTH = mac_pkg::IFMAP_BITWIDTH,
  parameter int DEPTH          = mac_pkg::DEPTH,
  parameter int LW             = $clog2(DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [LW-1:0]                    cfg_len,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  input  logic                             w_wr_valid,
  output logic                             w_wr_ready,
  input  logic signed [W_BITWIDTH-1:0]     w_wr_data,
  input  logic                             if_wr_valid,
  output logic                             if_wr_ready,
  input  logic signed [IFMAP_BITWIDTH-1:0] if_wr_data,
  output logic                             w_prefetch_out,
  output logic                             ifmap_start_out,
  output logic                             w_enable_out,
  output logic                             ifmap_enable_out,
  output logic signed [W_BITWIDTH-1:0]     w_data_out,
  output logic signed [IFMAP_BITWIDTH-1:0] ifmap_data_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  feeder_state_t state;
  logic [LW-1:0] len;
  logic [LW-1:0] w_cnt;
  logic [LW-1:0] if_cnt;
  logic [LW-1:0] str_cnt;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] last_idx;

  logic          w_we;
  logic          if_we;
  logic [LW-1:0] w_cnt_nxt;
  logic [LW-1:0] if_cnt_nxt;
  logic          load_complete;

  logic signed [W_BITWIDTH-1:0]     w_rd_data;
  logic signed [IFMAP_BITWIDTH-1:0] if_rd_data;

  // Ready depends only on registered state, so it is glitch-free toward the loader.
  assign busy        = (state != ST_IDLE);
  assign w_wr_ready  = (state == ST_LOAD) && (w_cnt < len);
  assign if_wr_ready = (state == ST_LOAD) && (if_cnt < len);

  assign w_we     = w_wr_valid && w_wr_ready;
  assign if_we    = if_wr_valid && if_wr_ready;
  assign last_idx = AW'(len - LW'(1));

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    w_cnt_nxt     = w_cnt + LW'(w_we);
    if_cnt_nxt    = if_cnt + LW'(if_we);
    load_complete = (w_cnt_nxt == len) && (if_cnt_nxt == len);
  end

  feeder_buf #(
    .WIDTH (W_BITWIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_wbuf (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_cnt[AW-1:0]),
    .wdata (w_wr_data),
    .raddr (rd_idx),
    .rdata (w_rd_data)
  );

  feeder_buf #(
    .WIDTH (IFMAP_BITWIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ibuf (
    .clk   (clk),
    .we    (if_we),
    .waddr (if_cnt[AW-1:0]),
    .wdata (if_wr_data),
    .raddr (rd_idx),
    .rdata (if_rd_data)
  );

  // rd_idx always points at the pair to emit on the next beat, so the
  // asynchronous buffer read feeds the registered data outputs directly.
  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      len              <= '0;
      w_cnt            <= '0;
      if_cnt           <= '0;
      str_cnt          <= '0;
      rd_idx           <= '0;
      done             <= 1'b0;
      err              <= 1'b0;
      w_prefetch_out   <= 1'b0;
      ifmap_start_out  <= 1'b0;
      w_enable_out     <= 1'b0;
      ifmap_enable_out <= 1'b0;
      w_data_out       <= '0;
      ifmap_data_out   <= '0;
    end else begin
      done             <= 1'b0;
      err              <= 1'b0;
      w_prefetch_out   <= 1'b0;
      ifmap_start_out  <= 1'b0;
      w_enable_out     <= 1'b0;
      ifmap_enable_out <= 1'b0;
      w_data_out       <= '0;
      ifmap_data_out   <= '0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len_legal(32'(cfg_len), DEPTH)) begin
              len    <= cfg_len;
              w_cnt  <= '0;
              if_cnt <= '0;
              rd_idx <= '0;
              state  <= ST_LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          w_cnt  <= w_cnt_nxt;
          if_cnt <= if_cnt_nxt;
          if (load_complete) begin
            state           <= ST_PREFETCH;
            w_prefetch_out  <= 1'b1;
            ifmap_start_out <= 1'b1;
            rd_idx          <= '0;
            str_cnt         <= '0;
          end
        end

        ST_PREFETCH: begin
          state            <= ST_STREAM;
          w_enable_out     <= 1'b1;
          ifmap_enable_out <= 1'b1;
          w_data_out       <= w_rd_data;
          ifmap_data_out   <= if_rd_data;
          if (rd_idx != last_idx) begin
            rd_idx <= rd_idx + AW'(1);
          end
        end

        ST_STREAM: begin
          if (str_cnt == len - LW'(1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            str_cnt          <= str_cnt + LW'(1);
            w_enable_out     <= 1'b1;
            ifmap_enable_out <= 1'b1;
            w_data_out       <= w_rd_data;
            ifmap_data_out   <= if_rd_data;
            if (rd_idx != last_idx) begin
              rd_idx <= rd_idx + AW'(1);
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder: a start-legality vector table plus scripted
// load/stream runs with hand-written weight and ifmap data.
module tb_mac_feeder;
  import mac_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             start;
  logic [LW-1:0]                    cfg_len;
  logic                             busy;
  logic                             done;
  logic                             err;
  logic                             w_wr_valid;
  logic                             w_wr_ready;
  logic signed [W_BITWIDTH-1:0]     w_wr_data;
  logic                             if_wr_valid;
  logic                             if_wr_ready;
  logic signed [IFMAP_BITWIDTH-1:0] if_wr_data;
  logic                             w_prefetch_out;
  logic                             ifmap_start_out;
  logic                             w_enable_out;
  logic                             ifmap_enable_out;
  logic signed [W_BITWIDTH-1:0]     w_data_out;
  logic signed [IFMAP_BITWIDTH-1:0] ifmap_data_out;

  mac_feeder #(
    .W_BITWIDTH     (W_BITWIDTH),
    .IFMAP_BITWIDTH (IFMAP_BITWIDTH),
    .DEPTH          (DEPTH),
    .LW             (LW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_len          (cfg_len),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .w_wr_valid       (w_wr_valid),
    .w_wr_ready       (w_wr_ready),
    .w_wr_data        (w_wr_data),
    .if_wr_valid      (if_wr_valid),
    .if_wr_ready      (if_wr_ready),
    .if_wr_data       (if_wr_data),
    .w_prefetch_out   (w_prefetch_out),
    .ifmap_start_out  (ifmap_start_out),
    .w_enable_out     (w_enable_out),
    .ifmap_enable_out (ifmap_enable_out),
    .w_data_out       (w_data_out),
    .ifmap_data_out   (ifmap_data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [W_BITWIDTH-1:0]     wv [DEPTH];
  logic signed [IFMAP_BITWIDTH-1:0] iv [DEPTH];

  typedef struct {
    logic [LW-1:0] cfg;
    logic          exp_err;
    logic          exp_busy;
  } start_vec_t;

  start_vec_t svec [6];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge, inputs are driven there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {21'd0, w_prefetch_out, ifmap_start_out, w_enable_out, ifmap_enable_out,
            done, err, busy, w_wr_ready, if_wr_ready,
            (w_data_out != '0), (ifmap_data_out != '0)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One full transaction. repulse_at / rst_at select a stream beat (-1 = never).
  task automatic run(input int len, input int w_delay, input int if_delay,
                     input int repulse_at, input int rst_at, input string tag);
    int wi  = 0;
    int ii  = 0;
    int cyc = 0;
    logic w_go, i_go;
    cfg_len = LW'(len);
    start   = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_in_load"}, busy, 1);

    while (!(wi == len && ii == len)) begin
      if (cyc > 200) begin
        check({tag, "_load_timeout"}, cyc, 0);
        break;
      end
      check($sformatf("%s_w_ready_c%0d", tag, cyc), w_wr_ready, (wi < len));
      check($sformatf("%s_if_ready_c%0d", tag, cyc), if_wr_ready, (ii < len));
      check($sformatf("%s_no_early_prefetch_c%0d", tag, cyc), w_prefetch_out, 0);
      w_go        = (cyc >= w_delay) && (wi < len);
      i_go        = (cyc >= if_delay) && (ii < len);
      w_wr_valid  = w_go;
      if_wr_valid = i_go;
      w_wr_data   = w_go ? wv[wi] : '0;
      if_wr_data  = i_go ? iv[ii] : '0;
      tick();
      if (w_go) wi++;
      if (i_go) ii++;
      cyc++;
    end
    w_wr_valid  = 1'b0;
    if_wr_valid = 1'b0;

    check({tag, "_prefetch"}, {ifmap_start_out, w_prefetch_out}, 3);
    check({tag, "_prefetch_no_enable"}, {ifmap_enable_out, w_enable_out}, 0);
    check({tag, "_prefetch_data_zero"}, {w_data_out != '0, ifmap_data_out != '0}, 0);
    check({tag, "_prefetch_ready_low"}, {w_wr_ready, if_wr_ready}, 0);
    tick();

    for (int k = 0; k < len; k++) begin
      check($sformatf("%s_enables_k%0d", tag, k), {ifmap_enable_out, w_enable_out}, 3);
      check($sformatf("%s_w_data_k%0d", tag, k), w_data_out, wv[k]);
      check($sformatf("%s_if_data_k%0d", tag, k), ifmap_data_out, iv[k]);
      check($sformatf("%s_no_strobe_k%0d", tag, k),
            {done, err, ifmap_start_out, w_prefetch_out}, 0);
      if (k == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check({tag, "_outs_after_rst"}, all_outs(), 0);
        return;
      end
      if (k == repulse_at) begin
        start   = 1'b1;
        cfg_len = LW'(3);
      end
      tick();
      start = 1'b0;
    end

    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_done_outs"}, {busy, ifmap_enable_out, w_enable_out,
                                w_data_out != '0, ifmap_data_out != '0}, 5'b10000);
    tick();
    check({tag, "_idle_after_done"}, all_outs(), 0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    cfg_len     = '0;
    w_wr_valid  = 1'b0;
    w_wr_data   = '0;
    if_wr_valid = 1'b0;
    if_wr_data  = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_outs", all_outs(), 0);

    // Start-legality table: illegal lengths pulse err and stay idle.
    svec[0] = '{LW'(0),  1'b1, 1'b0};
    svec[1] = '{LW'(17), 1'b1, 1'b0};
    svec[2] = '{LW'(31), 1'b1, 1'b0};
    svec[3] = '{LW'(1),  1'b0, 1'b1};
    svec[4] = '{LW'(16), 1'b0, 1'b1};
    svec[5] = '{LW'(8),  1'b0, 1'b1};
    for (int v = 0; v < 6; v++) begin
      cfg_len = svec[v].cfg;
      start   = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("vec%0d_err", v), err, svec[v].exp_err);
      check($sformatf("vec%0d_busy", v), busy, svec[v].exp_busy);
      tick();
      check($sformatf("vec%0d_err_one_cycle", v), err, 0);
      check($sformatf("vec%0d_busy_held", v), busy, svec[v].exp_busy);
      do_reset();
    end

    // Basic len=8 run with both ports valid every cycle.
    for (int i = 0; i < 8; i++) begin
      wv[i] = W_BITWIDTH'(-128 + 23 * i);
    end
    iv[0] = 16'sd1;    iv[1] = -16'sd2;  iv[2] = 16'sd4;   iv[3] = -16'sd8;
    iv[4] = 16'sd16;   iv[5] = -16'sd32; iv[6] = 16'sd64;  iv[7] = -16'sd128;
    check("wv_last_is_33", wv[7], 33);
    run(8, 0, 0, -1, -1, "basic");

    run(8, 0, 5, -1, -1, "if_delay5");
    run(8, 3, 0, -1, -1, "w_delay3");
    run(8, 0, 0, 3, -1, "restart_ignored");
    check("no_relatch_idle", busy, 0);

    run(8, 0, 0, -1, 2, "rst_mid_stream");
    wv[0] = 8'sd5;
    iv[0] = -16'sd3;
    run(1, 0, 0, -1, -1, "len1_after_rst");

    for (int i = 0; i < DEPTH; i++) begin
      wv[i] = W_BITWIDTH'(7 * i - 50);
      iv[i] = IFMAP_BITWIDTH'(1000 - 131 * i);
    end
    run(DEPTH, 0, 0, -1, -1, "full_depth");

    // Reset in the middle of a load.
    cfg_len    = LW'(4);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    w_wr_valid = 1'b1;
    w_wr_data  = 8'sd9;
    tick();
    w_wr_valid = 1'b0;
    rst        = 1'b1;
    tick();
    rst        = 1'b0;
    check("rst_mid_load_outs", all_outs(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameters: W_BITWIDTH=8 (weight width), IFMAP_BITWIDTH=16 (ifmap width), DEPTH=16 (maximum stream length), LW=$clog2(DEPTH)+1 (length field width).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle request; latches cfg_len; ignored unless state is IDLE.
REQ-005 cfg_len  in  LW  stream length; legal range 1..DEPTH.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 done  out  1  one-cycle pulse on stream completion.
REQ-008 err  out  1  one-cycle pulse when start carries an illegal cfg_len.
REQ-009 w_wr_valid / w_wr_ready / w_wr_data  in / out / W_BITWIDTH (signed)  weight load handshake.
REQ-010 if_wr_valid / if_wr_ready / if_wr_data  in / out / IFMAP_BITWIDTH (signed)  ifmap load handshake.
REQ-011 w_prefetch_out, ifmap_start_out  out  1  MAC-column prefetch/start strobes.
REQ-012 w_enable_out, ifmap_enable_out  out  1  MAC-column streaming enables.
REQ-013 w_data_out  out  W_BITWIDTH signed; ifmap_data_out  out  IFMAP_BITWIDTH signed  MAC-column data.

Function
REQ-014 Registered FSM states: IDLE, LOAD, PREFETCH, STREAM, DONE.
REQ-015 IDLE: start with 1<=cfg_len<=DEPTH latches len, clears w_cnt, if_cnt, rd_idx, and moves to LOAD.
REQ-016 IDLE: start with cfg_len=0 or cfg_len>DEPTH pulses err for one cycle and stays in IDLE.
REQ-017 LOAD: w_wr_ready=(w_cnt<len); if_wr_ready=(if_cnt<len); both ready outputs are 0 in every other state.
REQ-018 A handshake (valid&&ready) writes data into buffer[cnt] and increments that port's counter; the two ports are independent and may both transfer in the same cycle.
REQ-019 LOAD exits to PREFETCH on the cycle after both counters equal len.
REQ-020 PREFETCH lasts exactly 1 cycle: w_prefetch_out=1, ifmap_start_out=1, data outputs 0.
REQ-021 STREAM lasts exactly len cycles; on cycle k (k=0..len-1): w_enable_out=ifmap_enable_out=1, w_data_out=wbuf[k], ifmap_data_out=ibuf[k].
REQ-022 DONE lasts 1 cycle: done=1, all MAC-side outputs 0; next state IDLE.
REQ-023 Whenever the enables are 0, data outputs are driven to 0.
REQ-024 All MAC-side outputs are registered; strobes and enables never overlap.
REQ-025 start outside IDLE is ignored: no err pulse, no relatch.
REQ-026 rd_idx saturates at len-1 and never wraps; buffer writes beyond len are impossible because ready is 0.
REQ-027 A stalled load (valid held low) keeps the FSM in LOAD indefinitely, with no timeout.

Reset
REQ-028 rst=1 at a clock edge forces IDLE, clears counters and len, and drives all outputs to 0 on the next cycle, including mid-LOAD and mid-STREAM.
REQ-029 Buffer contents are not reset; no output ever exposes stale buffer data.

Structure
REQ-030 Package mac_pkg holds W_BITWIDTH, IFMAP_BITWIDTH, DEPTH and the feeder state enum; the MAC PE shares this package.
REQ-031 Sub-module feeder_buf (parameterised width/depth register file, 1 write port, 1 read port, no reset on storage) is instantiated twice: once for weights, once for ifmaps.

Verification
REQ-032 len=8, weights -128,-105,-82,...,33 (+23 steps), ifmaps 1,-2,4,...,-128, both valid every cycle -> 8 load cycles, 1 PREFETCH cycle, then 8 STREAM cycles emitting the pairs in order, then done pulse, then busy=0.
REQ-033 Same data with if_wr_valid delayed 5 cycles after the weights -> w_wr_ready drops after 8 weight transfers and PREFETCH occurs 1 cycle after the 8th ifmap transfer.
REQ-034 start with cfg_len=0, then with cfg_len=17 -> err pulses on both, busy stays 0.
REQ-035 rst asserted on the 3rd STREAM cycle -> next cycle all outputs are 0 and the FSM is in IDLE; a fresh len=1 run (weight 5, ifmap -3) then streams exactly (5,-3).
REQ-036 start re-pulsed during STREAM -> ignored; stream length and data are unchanged.
REQ-037 len=DEPTH=16 -> rd_idx reaches 15 without wrap, 16 enable cycles, and done is asserted once.
